plic_irq_gateway: RTL and testbench

PLIC_IRQ_GATEWAY -- requirements
Module: plic_irq_gateway

---
 rtl/uninasoc_pkg.sv | 24 ++
 rtl/plic_gateway_cell.sv | 93 +++++++++
 rtl/plic_irq_gateway.sv | 58 +++++
 tb/tb_plic_irq_gateway.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uninasoc_pkg.sv
// SoC-wide constants for the PLIC: interrupt line map, gateway state encoding
// and the default trigger mode of each line.
package uninasoc_pkg;

  localparam int PLIC_RESERVED_INTERRUPT = 0;
  localparam int PLIC_GPIO_INTERRUPT     = 1;
  localparam int PLIC_TIM0_INTERRUPT     = 2;
  localparam int PLIC_TIM1_INTERRUPT     = 3;
  localparam int PLIC_UART_INTERRUPT     = 4;

  localparam int PLIC_NUM_SOURCES = 32;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_t;

  // Timers pulse their interrupt; UART and GPIO hold theirs until serviced.
  localparam logic [PLIC_NUM_SOURCES-1:0] PLIC_DEFAULT_EDGE_MASK =
    (PLIC_NUM_SOURCES'(1) << PLIC_TIM0_INTERRUPT) |
    (PLIC_NUM_SOURCES'(1) << PLIC_TIM1_INTERRUPT);

endpackage

// File: rtl/plic_gateway_cell.sv
// One PLIC gateway line: input synchronizer, trigger detection and the
// IDLE/PENDING/CLAIMED request FSM with a coalescing re-pend flag.
module plic_gateway_cell
  import uninasoc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic claimed
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   sync_q;
  logic                   trig_q;
  logic                   repend_q;
  logic                   sync_out;
  logic                   trig_d;
  logic                   edge_trig;
  gw_state_t              state_q;

  assign sync_out  = sync_ff[SYNC_STAGES-1];
  // warm_q fills with ones as real samples reach sync_q, so a line that was
  // already high across reset release is not mistaken for a rising edge.
  assign trig_d    = sync_out & (~EDGE | (~sync_q & warm_q[SYNC_STAGES]));
  assign edge_trig = EDGE & trig_q;
  assign claimed   = (state_q == GW_CLAIMED);

  // NOTE: every flop here uses non-blocking assignment so that all stages
  // sample the previous-cycle value of their neighbour, as real flops do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
      warm_q  <= '0;
      sync_q  <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], src};
      warm_q  <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      sync_q  <= sync_out;
      trig_q  <= trig_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GW_IDLE;
      pending  <= 1'b0;
      repend_q <= 1'b0;
    end else begin
      case (state_q)
        GW_IDLE: begin
          if (trig_q) begin
            state_q <= GW_PENDING;
            pending <= 1'b1;
          end
        end
        GW_PENDING: begin
          if (edge_trig) repend_q <= 1'b1;
          if (claim) begin
            state_q <= GW_CLAIMED;
            pending <= 1'b0;
          end
        end
        GW_CLAIMED: begin
          if (complete) begin
            repend_q <= 1'b0;
            if (repend_q || trig_q) begin
              state_q <= GW_PENDING;
              pending <= 1'b1;
            end else begin
              state_q <= GW_IDLE;
            end
          end else if (edge_trig) begin
            repend_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= GW_IDLE;
          pending  <= 1'b0;
          repend_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/plic_irq_gateway.sv
// PLIC interrupt gateway array: one cell per source line 1..NUM_SRC-1, with
// claim/complete id decode and a registered error pulse for illegal requests.
module plic_irq_gateway
  import uninasoc_pkg::*;
#(
  parameter int unsigned        NUM_SRC     = 32,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0
) (
  input  logic                       clock_i,
  input  logic                       reset_ni,
  input  logic [NUM_SRC-1:0]         src_i,
  input  logic                       claim_valid_i,
  input  logic [$clog2(NUM_SRC)-1:0] claim_id_i,
  input  logic                       complete_valid_i,
  input  logic [$clog2(NUM_SRC)-1:0] complete_id_i,
  output logic [NUM_SRC-1:0]         pending_o,
  output logic                       err_o
);

  logic [NUM_SRC-1:0] pending_vec;
  logic [NUM_SRC-1:0] claimed_vec;
  logic               claim_ok;
  logic               complete_ok;
  logic               err_d;
  logic               unused_src0;

  // Line 0 is reserved: never pending, never claimed, its input is dropped.
  assign pending_vec[0] = 1'b0;
  assign claimed_vec[0] = 1'b0;
  assign unused_src0    = src_i[0];

  for (genvar k = 1; k < NUM_SRC; k++) begin : g_cell
    plic_gateway_cell #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE        (EDGE_MASK[k])
    ) u_cell (
      .clk      (clock_i),
      .rst_n    (reset_ni),
      .src      (src_i[k]),
      .claim    (claim_valid_i && (32'(claim_id_i) == k)),
      .complete (complete_valid_i && (32'(complete_id_i) == k)),
      .pending  (pending_vec[k]),
      .claimed  (claimed_vec[k])
    );
  end

  assign claim_ok    = (32'(claim_id_i) < NUM_SRC) && pending_vec[claim_id_i];
  assign complete_ok = (32'(complete_id_i) < NUM_SRC) && claimed_vec[complete_id_i];
  assign err_d       = (claim_valid_i && !claim_ok) || (complete_valid_i && !complete_ok);
  assign pending_o   = pending_vec;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) err_o <= 1'b0;
    else           err_o <= err_d;
  end

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Self-checking bench for plic_irq_gateway: directed scenarios plus random
// traffic against a sample-history reference model of the gateway rules.
module tb_plic_irq_gateway;
  import uninasoc_pkg::*;

  localparam int N   = PLIC_NUM_SOURCES;
  localparam int S   = 2;
  localparam int IDW = $clog2(N);
  localparam logic [N-1:0] MASK = PLIC_DEFAULT_EDGE_MASK;
  localparam int IDLE = 0, PEND = 1, CLMD = 2;

  logic           clock_i = 1'b0;
  logic           reset_ni = 1'b0;
  logic [N-1:0]   src_i = '0;
  logic           claim_valid_i = 1'b0;
  logic [IDW-1:0] claim_id_i = '0;
  logic           complete_valid_i = 1'b0;
  logic [IDW-1:0] complete_id_i = '0;
  logic [N-1:0]   pending_o;
  logic           err_o;

  plic_irq_gateway #(
    .NUM_SRC     (N),
    .SYNC_STAGES (S),
    .EDGE_MASK   (MASK)
  ) dut (
    .clock_i          (clock_i),
    .reset_ni         (reset_ni),
    .src_i            (src_i),
    .claim_valid_i    (claim_valid_i),
    .claim_id_i       (claim_id_i),
    .complete_valid_i (complete_valid_i),
    .complete_id_i    (complete_id_i),
    .pending_o        (pending_o),
    .err_o            (err_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int failures = 0;

  // Reference model: every sampled src vector since reset is kept; a sample
  // taken at edge j becomes the trigger condition evaluated at edge j+S+1.
  int           m_state[N];
  bit           m_repend[N];
  bit           m_err;
  logic [N-1:0] samples[$];

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (m_state[k] == PEND);
    return r;
  endfunction

  task automatic model_reset();
    samples.delete();
    for (int k = 0; k < N; k++) begin
      m_state[k]  = IDLE;
      m_repend[k] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    int ei;
    logic [N-1:0] trig;
    bit err;
    samples.push_back(src_i);
    ei = samples.size() - S - 2;
    trig = '0;
    if (ei >= 0) begin
      for (int k = 1; k < N; k++) begin
        if (!MASK[k]) trig[k] = samples[ei][k];
        else if (ei >= 1) trig[k] = samples[ei][k] && !samples[ei-1][k];
      end
    end
    err = (claim_valid_i && !(claim_id_i != 0 && int'(claim_id_i) < N &&
                              m_state[claim_id_i] == PEND)) ||
          (complete_valid_i && !(complete_id_i != 0 && int'(complete_id_i) < N &&
                                 m_state[complete_id_i] == CLMD));
    for (int k = 1; k < N; k++) begin
      bit hit_c, hit_d;
      hit_c = claim_valid_i && (int'(claim_id_i) == k);
      hit_d = complete_valid_i && (int'(complete_id_i) == k);
      case (m_state[k])
        IDLE: if (trig[k]) m_state[k] = PEND;
        PEND: begin
          if (MASK[k] && trig[k]) m_repend[k] = 1'b1;
          if (hit_c) m_state[k] = CLMD;
        end
        default: begin
          if (hit_d) begin
            m_state[k]  = (m_repend[k] || trig[k]) ? PEND : IDLE;
            m_repend[k] = 1'b0;
          end else if (MASK[k] && trig[k]) begin
            m_repend[k] = 1'b1;
          end
        end
      endcase
    end
    m_err = err;
  endtask

  task automatic tick();
    @(posedge clock_i);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    model_reset();
    #12;
    checks++;
    if (pending_o !== '0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: pending=%h err=%b required pending=0 err=0", pending_o, err_o);
    end
    src_i = '1;
    claim_valid_i = 1'b1;
    claim_id_i = IDW'(5);
    repeat (3) @(posedge clock_i);
    #1;
    checks++;
    if (pending_o !== '0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: pending=%h err=%b required pending=0 err=0", pending_o, err_o);
    end
    src_i = '0;
    claim_valid_i = 1'b0;
    @(negedge clock_i);
    reset_ni = 1'b1;
    repeat (5) tick();
    checks++;
    if (pending_o !== '0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_quiet: pending=%h err=%b required pending=0 err=0", pending_o, err_o);
    end
  endtask

  task automatic test_level_uart();
    src_i[4] = 1'b1;
    for (int i = 0; i <= S; i++) tick();
    checks++;
    if (pending_o[4] !== 1'b0) begin
      failures++;
      $display("FAIL uart_early: pending[4]=%b required 0", pending_o[4]);
    end
    tick();
    checks++;
    if (pending_o !== 32'h10) begin
      failures++;
      $display("FAIL uart_latency: pending=%h required 00000010", pending_o);
    end
    claim_valid_i = 1'b1;
    claim_id_i = IDW'(4);
    tick();
    claim_valid_i = 1'b0;
    checks++;
    if (pending_o[4] !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL uart_claim: pending[4]=%b err=%b required 0 0", pending_o[4], err_o);
    end
    repeat (2) tick();
    checks++;
    if (pending_o[4] !== 1'b0) begin
      failures++;
      $display("FAIL uart_held_claimed: pending[4]=%b required 0", pending_o[4]);
    end
    complete_valid_i = 1'b1;
    complete_id_i = IDW'(4);
    tick();
    complete_valid_i = 1'b0;
    checks++;
    if (pending_o[4] !== 1'b1 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL uart_repend: pending[4]=%b err=%b required 1 0", pending_o[4], err_o);
    end
    src_i[4] = 1'b0;
    repeat (S + 3) tick();
    claim_valid_i = 1'b1;
    tick();
    claim_valid_i = 1'b0;
    complete_valid_i = 1'b1;
    tick();
    complete_valid_i = 1'b0;
    checks++;
    if (pending_o !== m_pending() || pending_o !== '0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL uart_cleanup: pending=%h err=%b required pending=0 err=0", pending_o, err_o);
    end
  endtask

  task automatic test_edge_tim0();
    src_i[2] = 1'b1;
    tick();
    src_i[2] = 1'b0;
    repeat (S + 1) tick();
    checks++;
    if (pending_o !== 32'h4) begin
      failures++;
      $display("FAIL tim0_pend: pending=%h required 00000004", pending_o);
    end
    claim_valid_i = 1'b1;
    claim_id_i = IDW'(2);
    tick();
    claim_valid_i = 1'b0;
    repeat (3) begin
      src_i[2] = 1'b1;
      tick();
      src_i[2] = 1'b0;
      repeat (2) tick();
    end
    repeat (S + 2) tick();
    checks++;
    if (pending_o[2] !== 1'b0) begin
      failures++;
      $display("FAIL tim0_claimed: pending[2]=%b required 0", pending_o[2]);
    end
    complete_valid_i = 1'b1;
    complete_id_i = IDW'(2);
    tick();
    complete_valid_i = 1'b0;
    checks++;
    if (pending_o[2] !== 1'b1 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL tim0_coalesce: pending[2]=%b err=%b required 1 0", pending_o[2], err_o);
    end
    claim_valid_i = 1'b1;
    tick();
    claim_valid_i = 1'b0;
    complete_valid_i = 1'b1;
    tick();
    complete_valid_i = 1'b0;
    repeat (4) tick();
    checks++;
    if (pending_o[2] !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL tim0_single: pending[2]=%b err=%b required 0 0", pending_o[2], err_o);
    end
    complete_valid_i = 1'b1;
    tick();
    complete_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL tim0_double_complete: err=%b required 1", err_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL tim0_err_pulse: err=%b required 0", err_o);
    end
  endtask

  task automatic test_illegal();
    logic [N-1:0] snap;
    src_i[31] = 1'b1;
    repeat (S + 2) tick();
    src_i[31] = 1'b0;
    checks++;
    if (pending_o !== 32'h8000_0000) begin
      failures++;
      $display("FAIL illegal_setup: pending=%h required 80000000", pending_o);
    end
    snap = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      claim_valid_i = (i < 2);
      claim_id_i = (i == 0) ? IDW'(0) : IDW'(7);
      complete_valid_i = (i == 2);
      complete_id_i = IDW'(31);
      tick();
      checks++;
      if (err_o !== 1'b1 || pending_o !== snap) begin
        failures++;
        $display("FAIL illegal_op%0d: err=%b pending=%h required err=1 pending=%h",
                 i, err_o, pending_o, snap);
      end
    end
    claim_valid_i = 1'b0;
    complete_valid_i = 1'b0;
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_clear: err=%b required 0", err_o);
    end
    claim_valid_i = 1'b1;
    claim_id_i = IDW'(31);
    tick();
    claim_valid_i = 1'b0;
    complete_valid_i = 1'b1;
    tick();
    complete_valid_i = 1'b0;
    checks++;
    if (pending_o !== '0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL illegal_cleanup: pending=%h err=%b required 0 0", pending_o, err_o);
    end
  endtask

  task automatic test_same_cycle();
    src_i[3:2] = 2'b11;
    tick();
    src_i[3:2] = 2'b00;
    repeat (S + 1) tick();
    claim_valid_i = 1'b1;
    claim_id_i = IDW'(2);
    tick();
    claim_id_i = IDW'(3);
    complete_valid_i = 1'b1;
    complete_id_i = IDW'(2);
    tick();
    claim_valid_i = 1'b0;
    complete_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b0 || pending_o[3:2] !== 2'b00) begin
      failures++;
      $display("FAIL same_cycle_split: err=%b pending[3:2]=%b required 0 00", err_o, pending_o[3:2]);
    end
    complete_valid_i = 1'b1;
    complete_id_i = IDW'(3);
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_3claimed: err=%b required 0", err_o);
    end
    complete_id_i = IDW'(2);
    tick();
    complete_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_2idle: err=%b required 1", err_o);
    end
    src_i[2] = 1'b1;
    tick();
    src_i[2] = 1'b0;
    repeat (S + 1) tick();
    claim_valid_i = 1'b1;
    claim_id_i = IDW'(2);
    tick();
    complete_valid_i = 1'b1;
    complete_id_i = IDW'(2);
    tick();
    claim_valid_i = 1'b0;
    complete_valid_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || pending_o !== '0 || m_state[2] != IDLE) begin
      failures++;
      $display("FAIL same_id: err=%b pending=%h required err=1 pending=0", err_o, pending_o);
    end
  endtask

  task automatic test_reset_mid();
    src_i[4:1] = 4'b1111;
    tick();
    src_i[3] = 1'b0;
    repeat (S + 1) tick();
    claim_valid_i = 1'b1;
    claim_id_i = IDW'(2);
    tick();
    claim_valid_i = 1'b0;
    checks++;
    if (pending_o[4:1] !== 4'b1101) begin
      failures++;
      $display("FAIL reset_mid_setup: pending[4:1]=%b required 1101", pending_o[4:1]);
    end
    #2;
    reset_ni = 1'b0;
    model_reset();
    #1;
    checks++;
    if (pending_o !== '0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: pending=%h err=%b required 0 0", pending_o, err_o);
    end
    @(negedge clock_i);
    reset_ni = 1'b1;
    repeat (S + 1) tick();
    checks++;
    if (pending_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_early: pending[1]=%b required 0", pending_o[1]);
    end
    tick();
    checks++;
    if (pending_o !== 32'h12 || pending_o !== m_pending()) begin
      failures++;
      $display("FAIL reset_mid_release: pending=%h required 00000012", pending_o);
    end
    repeat (4) tick();
    checks++;
    if (pending_o[2] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_edge_held: pending[2]=%b required 0", pending_o[2]);
    end
  endtask

  function automatic logic [IDW-1:0] pick_id(int want);
    int start;
    start = $urandom_range(0, N - 1);
    if ($urandom_range(0, 3) != 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_state[(start + i) % N] == want) return IDW'((start + i) % N);
      end
    end
    return IDW'(start);
  endfunction

  task automatic test_random();
    src_i = '0;
    claim_valid_i = 1'b0;
    complete_valid_i = 1'b0;
    reset_ni = 1'b0;
    model_reset();
    @(negedge clock_i);
    reset_ni = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 15) == 0) src_i[k] = ~src_i[k];
      end
      claim_valid_i    = ($urandom_range(0, 9) < 3);
      claim_id_i       = pick_id(PEND);
      complete_valid_i = ($urandom_range(0, 9) < 3);
      complete_id_i    = pick_id(CLMD);
      tick();
      checks++;
      if (pending_o !== m_pending()) begin
        failures++;
        $display("FAIL rand_pending cycle %0d: pending=%h required %h", c, pending_o, m_pending());
      end
      checks++;
      if (err_o !== m_err) begin
        failures++;
        $display("FAIL rand_err cycle %0d: err=%b required %b", c, err_o, m_err);
      end
      checks++;
      if (pending_o[0] !== 1'b0) begin
        failures++;
        $display("FAIL rand_line0 cycle %0d: pending[0]=%b required 0", c, pending_o[0]);
      end
    end
    claim_valid_i = 1'b0;
    complete_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_level_uart();
    test_edge_tim0();
    test_illegal();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
